// File: rtl/render_rect_datapath.sv
// Rectangle raster datapath: stages x/y from a shared bus, then on start emits a BOX_W x BOX_H
// block of pixels, one per clock, with screen clipping on the adapter write-enable.
module render_rect_datapath #(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned BOX_W    = 4,
  parameter int unsigned BOX_H    = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [X_W-1:0]      data_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                ld_x,
  input  logic                ld_y,
  input  logic                start_count,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int unsigned ColW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int unsigned RowW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(BOX_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(BOX_H - 1);
  localparam logic [X_W:0]    ScrW    = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]    ScrH    = (Y_W + 1)'(SCREEN_H);

  typedef enum logic [1:0] {StIdle, StDraw, StFinish} state_e;

  state_e              state_q;
  logic [X_W-1:0]      x_stage_q, x0_q, x_out_q;
  logic [Y_W-1:0]      y_stage_q, y0_q, y_out_q;
  logic [COLOUR_W-1:0] colour_out_q;
  logic [ColW-1:0]     col_q, col_d;
  logic [RowW-1:0]     row_q, row_d;
  logic                plot_q, busy_q, done_q;

  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic           in_screen, last_pix;

  // col_d/row_d is the pixel emitted on this edge; on the start edge it is (0,0) taken
  // straight from the staging regs so the first pixel appears one cycle after start.
  always_comb begin
    base_x = x0_q;
    base_y = y0_q;
    col_d  = col_q;
    row_d  = row_q;
    if (state_q == StIdle) begin
      base_x = x_stage_q;
      base_y = y_stage_q;
      col_d  = '0;
      row_d  = '0;
    end else if (col_q == ColLast) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
    sum_x     = {1'b0, base_x} + {{(X_W + 1 - ColW){1'b0}}, col_d};
    sum_y     = {1'b0, base_y} + {{(Y_W + 1 - RowW){1'b0}}, row_d};
    in_screen = (sum_x < ScrW) && (sum_y < ScrH);
    last_pix  = (col_d == ColLast) && (row_d == RowLast);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      x_stage_q    <= '0;
      y_stage_q    <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (ld_x) x_stage_q <= data_in;
      if (ld_y) y_stage_q <= data_in[Y_W-1:0];
      plot_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (start_count) begin
            x0_q         <= x_stage_q;
            y0_q         <= y_stage_q;
            colour_out_q <= colour_in;
            col_q        <= col_d;
            row_q        <= row_d;
            x_out_q      <= sum_x[X_W-1:0];
            y_out_q      <= sum_y[Y_W-1:0];
            plot_q       <= in_screen;
            busy_q       <= 1'b1;
            state_q      <= last_pix ? StFinish : StDraw;
          end
        end
        StDraw: begin
          col_q   <= col_d;
          row_q   <= row_d;
          x_out_q <= sum_x[X_W-1:0];
          y_out_q <= sum_y[Y_W-1:0];
          plot_q  <= in_screen;
          state_q <= last_pix ? StFinish : StDraw;
        end
        StFinish: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_out_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_render_rect_datapath.sv
// Directed bench for render_rect_datapath: reset, full draw, clipping, wrap, mid-draw
// interference, back-to-back start and reset abort.
module tb_render_rect_datapath;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] data_in;
  logic [2:0] colour_in;
  logic       ld_x, ld_y, start_count;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot, busy, done;

  int total = 0;
  int bad   = 0;

  render_rect_datapath dut (
    .clk        (clk),
    .resetn     (resetn),
    .data_in    (data_in),
    .colour_in  (colour_in),
    .ld_x       (ld_x),
    .ld_y       (ld_y),
    .start_count(start_count),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] x, input logic [6:0] y);
    @(negedge clk);
    data_in = x;
    ld_x    = 1'b1;
    @(posedge clk); #1;
    ld_x    = 1'b0;
    data_in = {1'b0, y};
    ld_y    = 1'b1;
    @(posedge clk); #1;
    ld_y    = 1'b0;
  endtask

  // Pulses start, then checks each pixel and the done cycle; optional interference/abort.
  task automatic draw(input int x0, input int y0, input logic [2:0] c, input string nm,
                      input int inject_at, input int abort_at);
    int ex, ey;
    start_count = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      start_count = 1'b0;
      ld_x        = 1'b0;
      @(negedge clk);
      ex = x0 + (i % 4);
      ey = y0 + (i / 4);
      chk($sformatf("%s.x[%0d]", nm, i), {24'd0, x_out}, ex & 32'hFF);
      chk($sformatf("%s.y[%0d]", nm, i), {25'd0, y_out}, ey & 32'h7F);
      chk($sformatf("%s.col[%0d]", nm, i), {29'd0, colour_out}, {29'd0, c});
      chk($sformatf("%s.plot[%0d]", nm, i), {31'd0, plot}, (ex < 160 && ey < 120) ? 1 : 0);
      chk($sformatf("%s.busy[%0d]", nm, i), {31'd0, busy}, 1);
      chk($sformatf("%s.done[%0d]", nm, i), {31'd0, done}, 0);
      if (i == inject_at) begin
        start_count = 1'b1;
        ld_x        = 1'b1;
        data_in     = 8'd50;
        colour_in   = 3'b010;
      end
      if (i == abort_at) begin
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk({nm, ".abort_plot"}, {31'd0, plot}, 0);
        chk({nm, ".abort_busy"}, {31'd0, busy}, 0);
        chk({nm, ".abort_done"}, {31'd0, done}, 0);
        return;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, ".done"}, {31'd0, done}, 1);
    chk({nm, ".done_busy"}, {31'd0, busy}, 0);
    chk({nm, ".done_plot"}, {31'd0, plot}, 0);
  endtask

  task automatic idle_check(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s.plot[%0d]", nm, i), {31'd0, plot}, 0);
      chk($sformatf("%s.done[%0d]", nm, i), {31'd0, done}, 0);
      chk($sformatf("%s.busy[%0d]", nm, i), {31'd0, busy}, 0);
    end
  endtask

  initial begin
    resetn      = 1'b0;
    data_in     = '0;
    colour_in   = '0;
    ld_x        = 1'b0;
    ld_y        = 1'b0;
    start_count = 1'b0;

    // Reset held for three clocks
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.x", {24'd0, x_out}, 0);
    chk("rst.y", {25'd0, y_out}, 0);
    chk("rst.colour", {29'd0, colour_out}, 0);
    chk("rst.plot", {31'd0, plot}, 0);
    chk("rst.busy", {31'd0, busy}, 0);
    chk("rst.done", {31'd0, done}, 0);
    resetn = 1'b1;
    idle_check("idle", 5);

    // Basic draw, then a back-to-back draw started during the done cycle
    load(8'd10, 7'd20);
    colour_in = 3'b101;
    draw(10, 20, 3'b101, "t2", -1, -1);
    colour_in = 3'b110;
    draw(10, 20, 3'b110, "t2b", -1, -1);
    idle_check("t2idle", 2);
    chk("t2idle.xhold", {24'd0, x_out}, 13);
    chk("t2idle.yhold", {25'd0, y_out}, 23);

    // Partial clipping at the bottom-right corner
    load(8'd158, 7'd118);
    colour_in = 3'b011;
    draw(158, 118, 3'b011, "t3", -1, -1);

    // Coordinate wrap past port width: every pixel clipped
    load(8'd254, 7'd126);
    colour_in = 3'b001;
    draw(254, 126, 3'b001, "t4", -1, -1);

    // Start/load/colour changes mid-draw must not disturb the current draw
    load(8'd10, 7'd20);
    colour_in = 3'b101;
    draw(10, 20, 3'b101, "t5", 5, -1);
    idle_check("t5idle", 1);
    draw(50, 20, 3'b010, "t5n", -1, -1);

    // Reset abort at pixel 7, then a fresh full draw
    load(8'd30, 7'd40);
    colour_in = 3'b111;
    draw(30, 40, 3'b111, "t6", -1, 7);
    idle_check("t6idle", 3);
    load(8'd30, 7'd40);
    draw(30, 40, 3'b111, "t6n", -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
